// File: rtl/cnn_frame_feeder.sv
// cnn_frame_feeder: ingests one grayscale frame from a host byte stream into a
// local frame buffer, then replays it to CNN_TOP as a one-cycle start pulse
// followed by a gap-free pixel burst, and holds off the next frame until the
// CNN reports its result.
// Optional feature macro: FEEDER_TIMEOUT_EN (WAIT_RESULT watchdog).
module cnn_frame_feeder #(
  parameter int unsigned IMG_WIDTH      = 32,
  parameter int unsigned IMG_HEIGHT     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  input  logic        host_sof,
  output logic        host_ready,
  input  logic        result_valid,
  output logic        start_signal,
  output logic        pixel_valid,
  output logic [7:0]  pixel_in,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        sync_err,
  output logic        timeout_err
);

  localparam int unsigned IMG_SIZE  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned AW        = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_SIZE - 1);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [AW-1:0] r_wr_addr, w_wr_addr_nxt, w_wr_addr;
  logic [AW-1:0] r_rd_addr, w_rd_addr_nxt, w_rd_addr_inc;
  logic [AW-1:0] r_out_cnt, w_out_cnt_nxt;
  logic [15:0]   r_frame_count, w_frame_count_nxt;
  logic          r_sync_err, w_sync_err_nxt;
  logic          r_start, r_pixel_valid, r_busy;
  logic          w_wr_en;
  logic [7:0]    r_rd_data;
  logic [7:0]    r_mem [IMG_SIZE];

`ifdef FEEDER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_to_cnt, w_to_cnt_nxt;
  logic          r_timeout_err, w_timeout_err_nxt;
`else
  logic          w_unused_timeout_cfg;
`endif

  // Read pointer advance, wrapping at the end of the frame
  assign w_rd_addr_inc = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + AW'(1);

  // Next-state and datapath update logic
  always_comb begin
    w_state_nxt       = r_state;
    w_wr_addr_nxt     = r_wr_addr;
    w_rd_addr_nxt     = r_rd_addr;
    w_out_cnt_nxt     = r_out_cnt;
    w_frame_count_nxt = r_frame_count;
    w_sync_err_nxt    = r_sync_err;
    w_wr_en           = 1'b0;
    w_wr_addr         = r_wr_addr;
`ifdef FEEDER_TIMEOUT_EN
    w_to_cnt_nxt      = r_to_cnt;
    w_timeout_err_nxt = r_timeout_err;
`endif
    case (r_state)
      S_FILL: begin
        if (host_valid) begin
          w_wr_en = 1'b1;
          // A mid-frame SOF resynchronises the fill to pixel 0
          if (host_sof && (r_wr_addr != '0)) begin
            w_wr_addr      = '0;
            w_sync_err_nxt = 1'b1;
          end
          if (w_wr_addr == LAST_ADDR) begin
            w_wr_addr_nxt = '0;
            w_state_nxt   = S_START;
          end else begin
            w_wr_addr_nxt = w_wr_addr + AW'(1);
          end
        end
      end
      S_START: begin
        w_rd_addr_nxt = w_rd_addr_inc;
        w_out_cnt_nxt = '0;
        w_state_nxt   = S_STREAM;
      end
      S_STREAM: begin
        w_rd_addr_nxt = w_rd_addr_inc;
        if (r_out_cnt == LAST_ADDR) begin
          w_rd_addr_nxt = '0;
          w_out_cnt_nxt = '0;
          w_state_nxt   = S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
          w_to_cnt_nxt  = '0;
`endif
        end else begin
          w_out_cnt_nxt = r_out_cnt + AW'(1);
        end
      end
      S_WAIT: begin
        if (result_valid) begin
          w_frame_count_nxt = r_frame_count + 16'd1;
          w_state_nxt       = S_FILL;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = S_FILL;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TW'(1);
        end
`endif
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // State, pointers, flags and registered stream controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_out_cnt     <= '0;
      r_frame_count <= '0;
      r_sync_err    <= 1'b0;
      r_start       <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_busy        <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_rd_addr     <= w_rd_addr_nxt;
      r_out_cnt     <= w_out_cnt_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_sync_err    <= w_sync_err_nxt;
      r_start       <= (w_state_nxt == S_START);
      r_pixel_valid <= (w_state_nxt == S_STREAM);
      r_busy        <= (w_state_nxt != S_FILL);
`ifdef FEEDER_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
`endif
    end
  end

  // Frame buffer: synchronous write, registered read, contents never reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= host_data;
    end
    r_rd_data <= r_mem[r_rd_addr];
  end

  assign host_ready   = (r_state == S_FILL) & ~rst;
  assign start_signal = r_start;
  assign pixel_valid  = r_pixel_valid;
  assign pixel_in     = r_pixel_valid ? r_rd_data : 8'h00;
  assign busy         = r_busy;
  assign frame_count  = r_frame_count;
  assign sync_err     = r_sync_err;

`ifdef FEEDER_TIMEOUT_EN
  assign timeout_err  = r_timeout_err;
`else
  assign timeout_err          = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: doc/cnn_frame_feeder.md
# cnn_frame_feeder

Upstream ingest stage for `CNN_TOP`. It accepts a host byte stream of one grayscale frame over a valid/ready handshake and stores it in an internal frame buffer. It then replays the frame to `CNN_TOP` as a one-cycle `start_signal` followed by `IMG_WIDTH*IMG_HEIGHT` back-to-back `pixel_valid` cycles. It holds off the next frame until `CNN_TOP` reports `final_result_valid`.

## Interface
Parameters:
- `IMG_WIDTH`, default 32: pixels per row.
- `IMG_HEIGHT`, default 32: rows per frame. `IMG_SIZE = IMG_WIDTH*IMG_HEIGHT`; address width `AW = $clog2(IMG_SIZE)`.
- `TIMEOUT_CYCLES`, default 50000: watchdog limit, used only with `FEEDER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_valid`  in  1  host byte valid.
- `host_data`  in  8  host pixel byte.
- `host_sof`  in  1  qualifies `host_data` as pixel 0 of a frame.
- `host_ready`  out  1  feeder can accept a byte.
- `result_valid`  in  1  connect to `CNN_TOP.final_result_valid`.
- `start_signal`  out  1  frame-start pulse to `CNN_TOP`.
- `pixel_valid`  out  1  pixel strobe to `CNN_TOP`.
- `pixel_in`  out  8  pixel to `CNN_TOP`.
- `busy`  out  1  high in any state other than FILL.
- `frame_count`  out  16  number of completed frames; wraps at 0xFFFF→0.
- `sync_err`  out  1  sticky; set by `host_sof` arriving mid-fill.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Frame buffer: `IMG_SIZE` x 8 RAM, synchronous write, registered 1-cycle read. The buffer contents are not reset.
- States:
  - FILL (reset state): `host_ready=1`. A byte is accepted when `host_valid && host_ready` at the clock edge. It is written to `wr_addr`, then `wr_addr++`. Acceptance at `wr_addr==IMG_SIZE-1` moves to START and clears `wr_addr`.
  - START: exactly one cycle. `start_signal=1`. Issues the read of address 0. Next state is STREAM.
  - STREAM: `pixel_valid=1` for exactly `IMG_SIZE` consecutive cycles, with `pixel_in = mem[rd_addr]` in ascending order. After the last pixel, the next state is WAIT_RESULT.
  - WAIT_RESULT: when `result_valid` is sampled high, `frame_count++` and the next state is FILL.
- `host_sof` accepted in FILL:
  - If `wr_addr==0`: no effect beyond a normal write.
  - If `wr_addr!=0`: the byte is written to address 0, `wr_addr` becomes 1, and `sync_err` is set.
- `host_sof` while `host_ready=0` is ignored.
- `result_valid` outside WAIT_RESULT is ignored.
- `host_ready` is combinational `(state==FILL)`. It is 0 while `rst` is high.
- When `pixel_valid=0`, `pixel_in` is 0.

## Timing
- Reset values: `host_ready=0`, `start_signal=0`, `pixel_valid=0`, `pixel_in=0`, `busy=0`, `frame_count=0`, `sync_err=0`, `timeout_err=0`. Internal state: FILL, `wr_addr=0`, `rd_addr=0`.
- `host_ready=1` in the first cycle after `rst` deasserts.
- Let edge T be the acceptance of the last byte:
  - `start_signal=1` in cycle T+1.
  - `pixel_valid=1` in cycles T+2 .. T+1+IMG_SIZE. Pixel i appears in cycle T+2+i.
  - WAIT_RESULT begins in cycle T+2+IMG_SIZE.
- `result_valid` sampled high at edge R: `frame_count` updates and `host_ready=1` in cycle R+1.
- Host gaps (`host_valid=0`) during FILL stretch FILL only. The output stream is always gap-free.
- `rst` asserted in any state, including mid-STREAM, forces all outputs to their reset values asynchronously. The partial frame is discarded, and a full new frame must be received.

## Configuration
- `FEEDER_TIMEOUT_EN` defined:
  - A counter runs in WAIT_RESULT and clears on entry.
  - If it reaches `TIMEOUT_CYCLES` without `result_valid`, `timeout_err` is set (sticky until reset) and the next state is FILL.
  - `frame_count` is not incremented on timeout.
- `FEEDER_TIMEOUT_EN` undefined: no counter. WAIT_RESULT waits indefinitely, and `timeout_err` is tied to 0.

## Test plan
- Ramp frame (pixel i = i[7:0]) sent with continuous `host_valid` -> `start_signal` high exactly at T+1; 1024 contiguous `pixel_valid` with `pixel_in` 0x00..0xFF repeated 4 times; `host_ready=0` from T+1 until after `result_valid`.
- Same ramp with `host_valid` high every third cycle -> output stream identical to the first scenario, with only T shifted.
- `host_sof` on byte 500 of fill, value 0xAA -> `sync_err=1`; after 1023 more bytes, `start_signal` fires and the first `pixel_in` is 0xAA.
- `result_valid` pulse 20 cycles into WAIT_RESULT -> `frame_count` 0→1; a second frame of constant 0x5C streams as 1024 cycles of 0x5C.
- `rst` asserted at pixel 300 of STREAM -> `pixel_valid`, `start_signal`, `pixel_in` drop to 0 without waiting for a clock edge; `frame_count=0`; `host_ready=1` one cycle after release; no stream until 1024 new bytes arrive.
- `TIMEOUT_CYCLES=100`, no `result_valid`:
  - with `FEEDER_TIMEOUT_EN`: `timeout_err=1` and FILL after 100 WAIT_RESULT cycles; `frame_count` unchanged.
  - without the macro: WAIT_RESULT is held for 10000 cycles and `timeout_err` stays 0.
